// File: rtl/bus_device_port_if.sv
// Bus device port signal bundle.
// Device side uses slave; the environment side uses master.
interface bus_device_port_if #(
   parameter int N = 8
);
   logic [N-1:0] tx_data;
   logic         tx_valid;
   logic         tx_ready;
   logic         req;
   logic         grant;
   logic         peer_grant;
   logic [N-1:0] bus_out;
   logic         bus_oe;
   logic [N-1:0] bus_in;
   logic [N-1:0] rx_data;
   logic         rx_valid;
   logic         collision;

   modport slave (
      input  tx_data, tx_valid, grant, peer_grant, bus_in,
      output tx_ready, req, bus_out, bus_oe,
      output rx_data, rx_valid, collision
   );

   modport master (
      output tx_data, tx_valid, grant, peer_grant, bus_in,
      input  tx_ready, req, bus_out, bus_oe,
      input  rx_data, rx_valid, collision
   );
endinterface

// File: rtl/bus_device_port.sv
// Shared-bus device port: TX FIFO, request/burst FSM,
// RX capture of peer words and sticky collision flag.
module bus_device_port #(
   parameter int N         = 8,
   parameter int DEPTH     = 4,
   parameter int MAX_BURST = 4
) (
   input logic              clk,
   input logic              rst,
   bus_device_port_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(MAX_BURST + 1);

   typedef enum logic [1:0] {IDLE, REQ, XFER, HOLD} state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  mem_q [DEPTH];
   logic [N-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [BW-1:0] burst_q, burst_d;
   logic [N-1:0]  rx_data_q, rx_data_d;
   logic          rx_valid_q, rx_valid_d;
   logic          collision_q, collision_d;
   logic          full;
   logic          push;
   logic          pop;

   assign full = (count_q == CW'(DEPTH));
   assign push = bus.tx_valid && !full;
   assign pop  = (state_q == XFER) && bus.grant && (count_q != '0);

   assign bus.tx_ready  = !full;
   assign bus.req       = (state_q == REQ) || (state_q == XFER);
   assign bus.bus_oe    = pop;
   assign bus.bus_out   = pop ? mem_q[rd_ptr_q] : '0;
   assign bus.rx_data   = rx_data_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.collision = collision_q;

   // FIFO bookkeeping: push and pop may share a cycle
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = bus.tx_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Request/burst FSM; burst count lives only inside XFER
   always_comb begin
      state_d = state_q;
      burst_d = burst_q;
      case (state_q)
         IDLE: if (count_q != '0) state_d = REQ;
         REQ:  if (bus.grant) state_d = XFER;
         XFER: begin
            if (!pop) begin
               state_d = HOLD;
            end else begin
               burst_d = burst_q + BW'(1);
               if (count_d == '0 || burst_d == BW'(MAX_BURST)) begin
                  state_d = HOLD;
               end
            end
         end
         HOLD:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (state_d != XFER) burst_d = '0;
   end

   // Peer capture is suppressed when both grants overlap
   always_comb begin
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      collision_d = collision_q | (bus.grant & bus.peer_grant);
      if (bus.peer_grant && !bus.grant) begin
         rx_data_d  = bus.bus_in;
         rx_valid_d = 1'b1;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         mem_q       <= '{default: '0};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         burst_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         collision_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         burst_q     <= burst_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         collision_q <= collision_d;
      end
   end
endmodule

// File: tb/tb_bus_device_port.sv
// Directed bench for bus_device_port (N=8, DEPTH=4, MAX_BURST=4).
// Inputs change 1 time unit after each rising edge.
module tb_bus_device_port;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   bus_device_port_if #(.N(8)) bif ();

   bus_device_port #(
      .N(8),
      .DEPTH(4),
      .MAX_BURST(4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif.slave)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   initial begin
      rst            = 1'b1;
      bif.tx_data    = '0;
      bif.tx_valid   = 1'b0;
      bif.grant      = 1'b0;
      bif.peer_grant = 1'b0;
      bif.bus_in     = '0;
      tick();
      tick();
      #1;
      chk("rst_tx_ready", 32'(bif.tx_ready), 1);
      chk("rst_req", 32'(bif.req), 0);
      chk("rst_oe", 32'(bif.bus_oe), 0);
      chk("rst_out", 32'(bif.bus_out), 0);
      chk("rst_rx_data", 32'(bif.rx_data), 0);
      chk("rst_rx_valid", 32'(bif.rx_valid), 0);
      chk("rst_coll", 32'(bif.collision), 0);
      rst = 1'b0;
      tick();

      // two words with grant held high
      bif.grant    = 1'b1;
      bif.tx_valid = 1'b1;
      bif.tx_data  = 8'h11;
      tick();
      bif.tx_data = 8'h22;
      #1;
      chk("b2_idle_req", 32'(bif.req), 0);
      tick();
      bif.tx_valid = 1'b0;
      #1;
      chk("b2_req", 32'(bif.req), 1);
      chk("b2_req_oe", 32'(bif.bus_oe), 0);
      tick();
      chk("b2_w0_oe", 32'(bif.bus_oe), 1);
      chk("b2_w0", 32'(bif.bus_out), 32'h11);
      tick();
      chk("b2_w1_oe", 32'(bif.bus_oe), 1);
      chk("b2_w1", 32'(bif.bus_out), 32'h22);
      tick();
      chk("b2_hold_req", 32'(bif.req), 0);
      chk("b2_hold_oe", 32'(bif.bus_oe), 0);
      chk("b2_hold_out", 32'(bif.bus_out), 0);
      tick();
      chk("b2_idle2_req", 32'(bif.req), 0);
      tick();
      chk("b2_idle3_req", 32'(bif.req), 0);

      // six words against a four-deep FIFO, grant low
      bif.grant    = 1'b0;
      bif.tx_valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         bif.tx_data = 8'(i);
         tick();
      end
      chk("f6_full", 32'(bif.tx_ready), 0);
      bif.tx_data = 8'h05;
      tick();
      chk("f6_stall", 32'(bif.tx_ready), 0);
      chk("f6_req", 32'(bif.req), 1);
      chk("f6_oe_nogrant", 32'(bif.bus_oe), 0);
      bif.grant = 1'b1;
      #1;
      chk("f6_req_oe", 32'(bif.bus_oe), 0);
      tick();
      chk("f6_x1", 32'(bif.bus_out), 1);
      chk("f6_x1_rdy", 32'(bif.tx_ready), 0);
      tick();
      chk("f6_x2", 32'(bif.bus_out), 2);
      chk("f6_x2_rdy", 32'(bif.tx_ready), 1);
      tick();
      bif.tx_data = 8'h06;
      #1;
      chk("f6_x3", 32'(bif.bus_out), 3);
      tick();
      bif.tx_valid = 1'b0;
      #1;
      chk("f6_x4", 32'(bif.bus_out), 4);
      chk("f6_x4_oe", 32'(bif.bus_oe), 1);
      tick();
      chk("f6_hold_req", 32'(bif.req), 0);
      chk("f6_hold_oe", 32'(bif.bus_oe), 0);
      tick();
      chk("f6_idle_req", 32'(bif.req), 0);
      tick();
      chk("f6_rereq", 32'(bif.req), 1);
      tick();
      chk("f6_x5", 32'(bif.bus_out), 5);
      tick();
      chk("f6_x6", 32'(bif.bus_out), 6);
      tick();
      chk("f6_end_hold", 32'(bif.req), 0);
      tick();

      // grant withdrawn after the first of three words
      bif.grant    = 1'b0;
      bif.tx_valid = 1'b1;
      bif.tx_data  = 8'hA1;
      tick();
      bif.tx_data = 8'hA2;
      tick();
      bif.tx_data = 8'hA3;
      tick();
      bif.tx_valid = 1'b0;
      bif.grant    = 1'b1;
      #1;
      chk("gd_req", 32'(bif.req), 1);
      tick();
      chk("gd_w0", 32'(bif.bus_out), 32'hA1);
      tick();
      bif.grant = 1'b0;
      #1;
      chk("gd_drop_oe", 32'(bif.bus_oe), 0);
      chk("gd_drop_out", 32'(bif.bus_out), 0);
      tick();
      chk("gd_hold", 32'(bif.req), 0);
      tick();
      chk("gd_idle", 32'(bif.req), 0);
      tick();
      chk("gd_rereq", 32'(bif.req), 1);
      bif.grant = 1'b1;
      tick();
      chk("gd_w1", 32'(bif.bus_out), 32'hA2);
      tick();
      chk("gd_w2", 32'(bif.bus_out), 32'hA3);
      tick();
      chk("gd_hold2", 32'(bif.req), 0);
      bif.grant = 1'b0;
      tick();

      // peer word capture
      bif.peer_grant = 1'b1;
      bif.bus_in     = 8'hA5;
      tick();
      bif.peer_grant = 1'b0;
      bif.bus_in     = 8'h3C;
      #1;
      chk("rx_valid", 32'(bif.rx_valid), 1);
      chk("rx_data", 32'(bif.rx_data), 32'hA5);
      tick();
      chk("rx_pulse_end", 32'(bif.rx_valid), 0);
      chk("rx_hold", 32'(bif.rx_data), 32'hA5);

      // overlapping grants
      bif.grant      = 1'b1;
      bif.peer_grant = 1'b1;
      bif.bus_in     = 8'h5A;
      tick();
      bif.grant      = 1'b0;
      bif.peer_grant = 1'b0;
      #1;
      chk("coll_set", 32'(bif.collision), 1);
      chk("coll_no_rx", 32'(bif.rx_valid), 0);
      chk("coll_rx_kept", 32'(bif.rx_data), 32'hA5);
      tick();
      tick();
      chk("coll_sticky", 32'(bif.collision), 1);

      // reset in the middle of a burst
      bif.tx_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bif.tx_data = 8'hC0 + 8'(i);
         tick();
      end
      bif.tx_valid = 1'b0;
      bif.grant    = 1'b1;
      tick();
      chk("mr_w0", 32'(bif.bus_out), 32'hC0);
      tick();
      rst = 1'b1;
      #1;
      chk("mr_w1", 32'(bif.bus_out), 32'hC1);
      tick();
      rst = 1'b0;
      #1;
      chk("mr_req", 32'(bif.req), 0);
      chk("mr_oe", 32'(bif.bus_oe), 0);
      chk("mr_rdy", 32'(bif.tx_ready), 1);
      chk("mr_coll_clr", 32'(bif.collision), 0);
      chk("mr_rx_clr", 32'(bif.rx_data), 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("mr_quiet_oe", 32'(bif.bus_oe), 0);
         chk("mr_quiet_req", 32'(bif.req), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
